kv_lookup_arbiter_rr: RTL
=========================

// Module: kv_lookup_arbiter_rr
// PURPOSE
// N-port round-robin arbiter sharing one kv_map lookup engine among NUM_PORTS transport clients.
// Each port posts one key at a time. The request is held in a per-port pending slot until granted.
// Results are routed back to the requesting port. A watchdog returns a forced miss if the map never answers.
// Sits between the xport blocks (e2v/v2e/extra ports) and the kv_map find interface.
// PARAMETERS
// NUM_PORTS  4    number of client ports, >=2
// KEY_W      16   lookup key width
// VAL_W      112  lookup value width
// TIMEOUT    255  cycles in WAIT before a forced miss; 0 = watchdog disabled
// PORTS
// clk             in   1                clock
// rst             in   1                reset
// req_stb         in   NUM_PORTS        per-port lookup request pulse
// req_key         in   NUM_PORTS*KEY_W  per-port key; port i = [i*KEY_W +: KEY_W]
// req_busy        out  NUM_PORTS        port i pending slot occupied
// req_drop        out  NUM_PORTS        1-cycle pulse: request rejected because slot occupied
// res_stb         out  NUM_PORTS        one-hot response pulse to the granted port
// res_match       out  1                match flag; qualified by any res_stb
// res_value       out  VAL_W            value; qualified by any res_stb, 0 otherwise
// res_timeout     out  1                1-cycle pulse with res_stb when the watchdog forced the response
// find_key_stb    out  1                lookup start pulse to kv_map
// find_key        out  KEY_W            lookup key, held stable from find_key_stb until next grant
// find_res_stb    in   1                kv_map result pulse
// find_res_match  in   1                kv_map match
// find_res_value  in   VAL_W            kv_map value
// BEHAVIOUR
// - Reset: rst synchronous, active-high; clock clk.
//   - All outputs 0.
//   - pending=0, rr pointer last=NUM_PORTS-1 so port 0 has first priority.
//   - State IDLE; watchdog counter 0.
// - Capture, every state:
//   - req_stb[i] && !pending[i]: set pending[i], latch key_i, visible next cycle.
//   - req_stb[i] && pending[i]: request dropped, req_drop[i]=1 next cycle, stored key unchanged.
//   - req_busy = pending (registered).
// - FSM states IDLE -> ARB -> WAIT -> ARB.
//   - IDLE: go to ARB after one cycle.
//   - ARB, pending!=0:
//     - Grant g = first set bit searching last+1 .. last+NUM_PORTS, modulo NUM_PORTS.
//     - Next cycle: find_key_stb=1 (one cycle), find_key=key_g, last<=g, state WAIT, counter cleared.
//   - ARB, pending==0: stay; find_res_stb ignored (stray/late results are discarded).
//   - WAIT, find_res_stb (accepted from the find_key_stb cycle onward):
//     - Next cycle: res_stb[g]=1, res_match/res_value copied from kv_map.
//     - pending[g] cleared; state ARB.
//   - WAIT, TIMEOUT!=0 and counter reaches TIMEOUT-1 without find_res_stb:
//     - Next cycle: res_stb[g]=1, res_match=0, res_value=0, res_timeout=1.
//     - pending[g] cleared; state ARB.
// - Latency: req_stb at cycle 0 on an idle arbiter -> find_key_stb at cycle 2.
//   - find_res_stb at cycle t -> res_stb at t+1; next grant's find_key_stb at t+2.
// - Simultaneous events:
//   - Pending clear has priority over the capture test in the same cycle, so req_stb[g] in the response cycle is dropped.
//   - A port's new request is accepted from the cycle after res_stb[g].
// - Fairness: a continuously requesting port waits at most NUM_PORTS-1 other lookups.
// - rst mid-lookup: pending and grant discarded, no res_stb is issued, a later find_res_stb is ignored.
// TESTING
// - Single port 1 req key=0x1234 at c0; map answers match=1 value=0xAB 3 cycles after find_key_stb
//   -> find_key_stb at c2 with key 0x1234; res_stb=4'b0010 with value 0xAB at c6.
// - All 4 ports req at same cycle -> find_key order 0,1,2,3; one res_stb per port, one-hot, correct keys.
// - Port 2 saturating, port 0 requests once -> port 0 granted within 1 lookup of its pending set.
// - Port 1 req_stb again while busy -> req_drop[1] pulse, original key looked up, single response.
// - TIMEOUT=8, map silent -> res_stb[g] with res_timeout=1 and match=0 8 cycles after find_key_stb.
//   - Late find_res_stb afterwards produces no res_stb.
// - rst asserted in WAIT -> all outputs 0 next cycle; subsequent find_res_stb ignored; fresh request served.

Source files
------------

// File: rtl/kv_lookup_arbiter_rr.sv
// ---------------------------------------------------------------------------
// kv_lookup_arbiter_rr
//
// Round-robin arbiter that shares one kv_map lookup engine among NUM_PORTS
// transport clients. Each port owns a one-deep pending slot holding its key.
// The arbiter grants one pending port at a time and issues a lookup to
// kv_map. The result is routed back to the granted port. If kv_map never
// answers within TIMEOUT cycles, a watchdog returns a forced miss.
//
// Handshake semantics: every *_stb signal is a single-cycle pulse with no
// back-pressure. Data that goes with a strobe is valid only in the strobe
// cycle, except find_key, which stays stable from find_key_stb until the
// next grant. A request arriving while its port's slot is occupied is
// rejected with a one-cycle req_drop pulse.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_stb/req_key per-port request pulse and key (port i = [i*KEY_W +: KEY_W])
//   req_busy        per-port pending slot occupied
//   req_drop        per-port pulse: request rejected, slot occupied
//   res_stb         one-hot response pulse to the granted port
//   res_match       match flag, qualified by res_stb
//   res_value       value, qualified by res_stb, 0 otherwise
//   res_timeout     pulse with res_stb when the watchdog forced the response
//   find_key_stb    lookup start pulse to kv_map
//   find_key        lookup key to kv_map
//   find_res_*      kv_map result pulse, match flag and value
//   dbg_state       current FSM state (0 IDLE, 1 ARB, 2 WAIT)
// ---------------------------------------------------------------------------
module kv_lookup_arbiter_rr #(
    parameter int NUM_PORTS = 4,
    parameter int KEY_W     = 16,
    parameter int VAL_W     = 112,
    parameter int TIMEOUT   = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PORTS-1:0]       req_stb,
    input  logic [NUM_PORTS*KEY_W-1:0] req_key,
    output logic [NUM_PORTS-1:0]       req_busy,
    output logic [NUM_PORTS-1:0]       req_drop,
    output logic [NUM_PORTS-1:0]       res_stb,
    output logic                       res_match,
    output logic [VAL_W-1:0]           res_value,
    output logic                       res_timeout,
    output logic                       find_key_stb,
    output logic [KEY_W-1:0]           find_key,
    input  logic                       find_res_stb,
    input  logic                       find_res_match,
    input  logic [VAL_W-1:0]           find_res_value,
    output logic [1:0]                 dbg_state
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [NUM_PORTS-1:0] ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] pending_q;
    logic [KEY_W-1:0]     key_q [NUM_PORTS];
    logic [PW-1:0]        last_q;
    logic [CW-1:0]        cnt_q;

    logic [NUM_PORTS-1:0] eligible;
    logic [PW-1:0]        gnt;
    logic                 gnt_found;
    logic                 do_grant;
    logic                 do_resp;
    logic                 do_tmo;

    assign req_busy  = pending_q;
    assign dbg_state = state_q;

    // The port being answered still shows pending during its res_stb cycle
    // (so a same-cycle request is dropped); keep it out of arbitration then.
    assign eligible = pending_q & ~res_stb;

    // Round-robin search starting just after the last granted port.
    always_comb begin
        int idx;
        idx       = 0;
        gnt       = '0;
        gnt_found = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(last_q) + k) % NUM_PORTS;
            if (!gnt_found && eligible[idx]) begin
                gnt       = PW'(idx);
                gnt_found = 1'b1;
            end
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d  = state_q;
        do_grant = 1'b0;
        do_resp  = 1'b0;
        do_tmo   = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_ARB;
            S_ARB: begin
                // Results arriving here are stray or late and are discarded.
                if (gnt_found) begin
                    do_grant = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (find_res_stb) begin
                    do_resp = 1'b1;
                    state_d = S_ARB;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    do_tmo  = 1'b1;
                    state_d = S_ARB;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            last_q       <= PW'(NUM_PORTS - 1);
            cnt_q        <= '0;
            req_drop     <= '0;
            res_stb      <= '0;
            res_match    <= 1'b0;
            res_value    <= '0;
            res_timeout  <= 1'b0;
            find_key_stb <= 1'b0;
            find_key     <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                key_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;

            // Lookup issue and watchdog counter.
            find_key_stb <= do_grant;
            if (do_grant) begin
                find_key <= key_q[gnt];
                last_q   <= gnt;
                cnt_q    <= '0;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end

            // Response to the granted port (last_q holds it during WAIT).
            res_stb     <= (do_resp || do_tmo) ? (ONE << last_q) : '0;
            res_match   <= do_resp & find_res_match;
            res_value   <= do_resp ? find_res_value : '0;
            res_timeout <= do_tmo;

            // Pending slots: clearing on res_stb wins over a new capture.
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_drop[i] <= 1'b0;
                if (res_stb[i]) begin
                    pending_q[i] <= 1'b0;
                    req_drop[i]  <= req_stb[i];
                end else if (req_stb[i]) begin
                    if (pending_q[i]) begin
                        req_drop[i] <= 1'b1;
                    end else begin
                        pending_q[i] <= 1'b1;
                        key_q[i]     <= req_key[i*KEY_W +: KEY_W];
                    end
                end
            end
        end
    end

endmodule
